// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single-port word memory. Port 0 is the CPU
// memory stage and port 1 is the debug/loader port. One transaction is in
// flight at a time: IDLE latches a request, ACCESS drives the memory strobe,
// and RESP returns read data one cycle after the memory read.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   req[1:0]          per-port request level, held until gnt
//   we[1:0]           per-port write enable, qualified by req
//   addr0/addr1       per-port byte address
//   wdata0/wdata1     per-port write data
//   gnt[1:0]          one-cycle acceptance pulse, owner bit only
//   rvalid[1:0]       one-cycle read-data-valid pulse, owner bit only
//   err[1:0]          one-cycle error pulse, coincident with gnt
//   rdata             read data, zero unless an rvalid bit is set
//   busy              high whenever the FSM is not IDLE
//   mem_en/mem_we     memory access and write strobes
//   mem_addr          word index into the memory
//   mem_wdata         memory write data
//   mem_rdata         memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_WORDS = 128,
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [1:0]    err,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            owner_reg, owner_next;
  logic            last_owner_reg, last_owner_next;
  logic            we_reg, we_next;
  logic            err_reg, err_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;

  // Candidate selection from the live request lines; only consumed in IDLE.
  logic            sel;
  logic [31:0]     sel_addr;
  logic            sel_bad;

  always_comb begin
    // Under contention the port that did not own the last transaction wins.
    sel      = (req == 2'b11) ? ~last_owner_reg : req[1];
    sel_addr = sel ? addr1 : addr0;
    sel_bad  = (sel_addr[1:0] != 2'b00) ||
               ({2'b00, sel_addr[31:2]} >= 32'(MEM_WORDS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;  // port 0 wins the first contention
      we_reg         <= 1'b0;
      err_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      we_reg         <= we_next;
      err_reg        <= err_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    we_next         = we_reg;
    err_next        = err_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          state_next      = ACCESS;
          owner_next      = sel;
          last_owner_next = sel;
          we_next         = we[sel];
          err_next        = sel_bad;
          addr_next       = sel_addr[AW+1:2];
          wdata_next      = sel ? wdata1 : wdata0;
        end
      end
      ACCESS:  state_next = (err_reg || we_reg) ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output below is decoded from registers (plus mem_rdata for the
  // read return path), so reset clears them without waiting for a clock.
  logic access_ok;

  always_comb begin
    access_ok = (state_reg == ACCESS) && !err_reg;
    busy      = (state_reg != IDLE);
    mem_en    = access_ok;
    mem_we    = access_ok && we_reg;
    mem_addr  = access_ok ? addr_reg : '0;
    mem_wdata = access_ok ? wdata_reg : '0;
    rdata     = (state_reg == RESP) ? mem_rdata : '0;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic is_owner;
    assign is_owner   = (owner_reg == (gi == 1));
    assign gnt[gi]    = (state_reg == ACCESS) && is_owner;
    assign err[gi]    = (state_reg == ACCESS) && is_owner && err_reg;
    assign rvalid[gi] = (state_reg == RESP) && is_owner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed vector table, hand-written multi-cycle sequences (contention,
// continuous round-robin, reset during ACCESS) and a randomized two-agent run
// checked against a transaction-level schedule model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int MEM_WORDS = 128;
  localparam int AW        = 7;
  localparam int NCYC      = 1500;
  localparam int NR        = NCYC + 4;

  logic          clk, rst;
  logic [1:0]    req, we;
  logic [31:0]   addr0, addr1, wdata0, wdata1;
  logic [1:0]    gnt, rvalid, err;
  logic [31:0]   rdata;
  logic          busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the arbiter sits in front of; garbage on mem_rdata when not reading.
  logic [31:0] sram [MEM_WORDS];
  logic        sram_init;
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < MEM_WORDS; i++) sram[i] <= 32'(i);
    end else if (mem_en && mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    else                   mem_rdata <= $urandom;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic init);
    @(negedge clk);
    rst = 1'b1; sram_init = init; req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; sram_init = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  x_gnt, x_err;
    logic        x_en, x_we;
    logic [6:0]  x_maddr;
    logic [31:0] x_wdata;
    logic [1:0]  x_rv;
    logic [31:0] x_rd;
  } vec_t;

  function automatic vec_t mkv(string n, logic [1:0] r, logic [1:0] w,
      logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
      logic [1:0] xg, logic [1:0] xe, logic xen, logic xwe, logic [6:0] xma,
      logic [31:0] xwd, logic [1:0] xrv, logic [31:0] xrd);
    vec_t v;
    v.name = n; v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.x_gnt = xg; v.x_err = xe; v.x_en = xen; v.x_we = xwe; v.x_maddr = xma;
    v.x_wdata = xwd; v.x_rv = xrv; v.x_rd = xrd;
    return v;
  endfunction

  vec_t vecs[12];

  // ---------------- randomized run: schedule model ----------------
  logic [1:0]  e_gnt [NR];
  logic [1:0]  e_err [NR];
  logic [1:0]  e_rv  [NR];
  logic        e_busy[NR];
  logic        e_en  [NR];
  logic        e_we  [NR];
  logic [6:0]  e_addr[NR];
  logic [31:0] e_wd  [NR];
  logic [31:0] e_rd  [NR];
  logic [31:0] model_mem [MEM_WORDS];
  int          free_at;
  int          m_last;
  logic [1:0]  pend, pwe;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];

  function automatic logic [31:0] rand_addr();
    int r = int'($urandom_range(0, 9));
    logic [31:0] a = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
    if (r == 7) a = a + 32'($urandom_range(1, 3));
    else if (r > 7) a = $urandom | 32'h200;
    return a;
  endfunction

  // Decide what the arbiter accepts at edge e from the inputs now on the pins.
  task automatic model_eval(input int e);
    int s, idx;
    logic [31:0] a, d;
    logic w, bad;
    if (e >= free_at && req != 2'b00) begin
      s = (req == 2'b11) ? (1 - m_last) : ((req == 2'b10) ? 1 : 0);
      m_last = s;
      a   = (s == 1) ? addr1 : addr0;
      d   = (s == 1) ? wdata1 : wdata0;
      w   = we[s];
      bad = (a % 4 != 0) || (a / 4 >= MEM_WORDS);
      idx = int'(a / 4);
      e_gnt[e]  = 2'(1 << s);
      e_busy[e] = 1'b1;
      free_at   = e + 2;
      if (bad) begin
        e_err[e] = 2'(1 << s);
      end else begin
        e_en[e] = 1'b1; e_we[e] = w; e_addr[e] = 7'(idx); e_wd[e] = d;
        if (w) begin
          model_mem[idx] = d;
        end else begin
          e_rv[e+1] = 2'(1 << s); e_rd[e+1] = model_mem[idx];
          e_busy[e+1] = 1'b1; free_at = e + 3;
        end
      end
      $display("TXN cyc=%0d port=%0d we=%0d addr=%h bad=%0d", e, s, w, a, bad);
    end
  endtask

  task automatic drive_agents(input logic [1:0] g);
    for (int p = 0; p < 2; p++) begin
      if (g[p]) pend[p] = 1'b0;
      else if (pend[p] && $urandom_range(0, 19) == 0) pend[p] = 1'b0;
      if (!pend[p] && $urandom_range(0, 2) == 0) begin
        pend[p] = 1'b1; pwe[p] = 1'($urandom_range(0, 1));
        paddr[p] = rand_addr(); pwdata[p] = $urandom;
      end
    end
    req = pend; we = pwe;
    addr0 = paddr[0]; addr1 = paddr[1]; wdata0 = pwdata[0]; wdata1 = pwdata[1];
  endtask

  task automatic compare(input int c);
    chk($sformatf("r_gnt_%0d", c), 32'(gnt), 32'(e_gnt[c]));
    chk($sformatf("r_err_%0d", c), 32'(err), 32'(e_err[c]));
    chk($sformatf("r_rvalid_%0d", c), 32'(rvalid), 32'(e_rv[c]));
    chk($sformatf("r_rdata_%0d", c), rdata, (e_rv[c] != 0) ? e_rd[c] : 32'h0);
    chk($sformatf("r_busy_%0d", c), 32'(busy), 32'(e_busy[c]));
    chk($sformatf("r_mem_en_%0d", c), 32'(mem_en), 32'(e_en[c]));
    if (e_en[c]) begin
      chk($sformatf("r_mem_we_%0d", c), 32'(mem_we), 32'(e_we[c]));
      chk($sformatf("r_mem_addr_%0d", c), 32'(mem_addr), 32'(e_addr[c]));
      if (e_we[c]) chk($sformatf("r_mem_wdata_%0d", c), mem_wdata, e_wd[c]);
    end
    if (e_err[c] != 0) chk($sformatf("r_err_mem_we_%0d", c), 32'(mem_we), 32'h0);
  endtask

  int g_win[2];
  logic [1:0] g_val[2];
  logic [31:0] g_addr[2], g_wd[2];
  int ng;
  int owners[$];
  logic [31:0] w8;

  initial begin
    rst = 1'b0; sram_init = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pend = 2'b00; pwe = 2'b00;
    paddr[0] = '0; paddr[1] = '0; pwdata[0] = '0; pwdata[1] = '0;

    // Reset state, asserted before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; sram_init = 1'b0;

    // Vector table; each row is a one-cycle request pulse from idle.
    vecs[0]  = mkv("p0_rd_0x10",    2'b01, 2'b00, 32'h10, 0, 0, 0, 2'b01, 2'b00, 1, 0, 7'd4, 0, 2'b01, 32'h4);
    vecs[1]  = mkv("p1_rd_misalign",2'b10, 2'b00, 0, 32'h6, 0, 0, 2'b10, 2'b10, 0, 0, 7'd0, 0, 2'b00, 0);
    vecs[2]  = mkv("p1_rd_oor",     2'b10, 2'b00, 0, 32'h200, 0, 0, 2'b10, 2'b10, 0, 0, 7'd0, 0, 2'b00, 0);
    vecs[3]  = mkv("p1_wr_0x40",    2'b10, 2'b10, 0, 32'h40, 0, 32'hDEADBEEF, 2'b10, 2'b00, 1, 1, 7'd16, 32'hDEADBEEF, 2'b00, 0);
    vecs[4]  = mkv("p0_rd_0x40",    2'b01, 2'b00, 32'h40, 0, 0, 0, 2'b01, 2'b00, 1, 0, 7'd16, 0, 2'b01, 32'hDEADBEEF);
    vecs[5]  = mkv("both_rd",       2'b11, 2'b00, 32'h4, 32'h8, 0, 0, 2'b10, 2'b00, 1, 0, 7'd2, 0, 2'b10, 32'h2);
    vecs[6]  = mkv("p0_wr_top",     2'b01, 2'b01, 32'h1FC, 0, 32'h12345678, 0, 2'b01, 2'b00, 1, 1, 7'd127, 32'h12345678, 2'b00, 0);
    vecs[7]  = mkv("p1_rd_top",     2'b10, 2'b00, 0, 32'h1FC, 0, 0, 2'b10, 2'b00, 1, 0, 7'd127, 0, 2'b10, 32'h12345678);
    vecs[8]  = mkv("p0_wr_misalign",2'b01, 2'b01, 32'h3, 0, 32'hFFFFFFFF, 0, 2'b01, 2'b01, 0, 0, 7'd0, 0, 2'b00, 0);
    vecs[9]  = mkv("both_wr",       2'b11, 2'b11, 32'h0, 32'h4, 32'h55, 32'h66, 2'b10, 2'b00, 1, 1, 7'd1, 32'h66, 2'b00, 0);
    vecs[10] = mkv("p0_rd_word0",   2'b01, 2'b00, 32'h0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 7'd0, 0, 2'b01, 32'h0);
    vecs[11] = mkv("p0_rd_word1",   2'b01, 2'b00, 32'h4, 0, 0, 0, 2'b01, 2'b00, 1, 0, 7'd1, 0, 2'b01, 32'h66);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = vecs[i].req; we = vecs[i].we;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
      @(posedge clk);
      @(negedge clk);
      req = 2'b00;
      chk({vecs[i].name, "_gnt"}, 32'(gnt), 32'(vecs[i].x_gnt));
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].x_err));
      chk({vecs[i].name, "_mem_en"}, 32'(mem_en), 32'(vecs[i].x_en));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'h1);
      chk({vecs[i].name, "_mem_we"}, 32'(mem_we), 32'(vecs[i].x_en & vecs[i].x_we));
      if (vecs[i].x_en) chk({vecs[i].name, "_mem_addr"}, 32'(mem_addr), 32'(vecs[i].x_maddr));
      if (vecs[i].x_en && vecs[i].x_we) chk({vecs[i].name, "_mem_wdata"}, mem_wdata, vecs[i].x_wdata);
      @(negedge clk);
      chk({vecs[i].name, "_rvalid"}, 32'(rvalid), 32'(vecs[i].x_rv));
      chk({vecs[i].name, "_rdata"}, rdata, (vecs[i].x_rv != 0) ? vecs[i].x_rd : 32'h0);
      chk({vecs[i].name, "_busy2"}, 32'(busy), 32'(vecs[i].x_rv != 0));
      @(negedge clk);
      chk({vecs[i].name, "_quiet"}, {25'h0, busy, gnt, rvalid, err}, 32'h0);
      $display("VEC %s done", vecs[i].name);
    end

    // Simultaneous writes right after reset: port 0 first, port 1 two cycles later.
    do_reset(1'b0);
    req = 2'b11; we = 2'b11;
    addr0 = 32'h8; wdata0 = 32'hAA; addr1 = 32'hC; wdata1 = 32'hBB;
    ng = 0; g_win[0] = -1; g_win[1] = -1; g_val[0] = '0; g_val[1] = '0;
    g_addr[0] = '0; g_addr[1] = '0; g_wd[0] = '0; g_wd[1] = '0;
    for (int w = 0; w < 12 && ng < 2; w++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt != 2'b00) begin
        g_win[ng] = w; g_val[ng] = gnt; g_addr[ng] = 32'(mem_addr); g_wd[ng] = mem_wdata;
        req = req & ~gnt;
        ng++;
      end
    end
    chk("contend_first_gnt", 32'(g_val[0]), 32'h1);
    chk("contend_first_addr", g_addr[0], 32'h2);
    chk("contend_first_wdata", g_wd[0], 32'hAA);
    chk("contend_second_gnt", 32'(g_val[1]), 32'h2);
    chk("contend_second_addr", g_addr[1], 32'h3);
    chk("contend_second_wdata", g_wd[1], 32'hBB);
    chk("contend_gap", 32'(g_win[1] - g_win[0]), 32'h2);
    $display("SEQ contention grants at windows %0d and %0d", g_win[0], g_win[1]);
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Continuous reads from both ports: strict alternation starting with port 0.
    req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
    owners.delete();
    for (int w = 0; w < 30; w++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt == 2'b01) owners.push_back(0);
      else if (gnt == 2'b10) owners.push_back(1);
      else if (gnt != 2'b00) owners.push_back(9);
    end
    req = 2'b00;
    chk("rr_count", 32'(owners.size()), 32'd10);
    foreach (owners[k]) chk($sformatf("rr_owner_%0d", k), 32'(owners[k]), 32'(k % 2));
    $display("SEQ round-robin saw %0d grants", owners.size());
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a write: strobes drop at once, memory untouched.
    w8 = sram[8];
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    chk("rstmid_pre_en", 32'(mem_en), 32'h1);
    rst = 1'b1; req = 2'b00;
    #1;
    chk("rstmid_mem_en", 32'(mem_en), 32'h0);
    chk("rstmid_mem_we", 32'(mem_we), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_gnt", 32'(gnt), 32'h0);
    chk("rstmid_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk($sformatf("rstmid_quiet_%0d", w), {25'h0, busy, gnt, rvalid, err}, 32'h0);
    end
    chk("rstmid_word8", sram[8], w8);
    $display("SEQ reset during write access done");

    // Randomized run against the schedule model.
    do_reset(1'b1);
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 32'(i);
    for (int i = 0; i < NR; i++) begin
      e_gnt[i] = '0; e_err[i] = '0; e_rv[i] = '0; e_busy[i] = 1'b0;
      e_en[i] = 1'b0; e_we[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
    end
    free_at = 0; m_last = 1; pend = 2'b00;
    drive_agents(2'b00);
    model_eval(0);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      @(negedge clk);
      compare(c);
      drive_agents(e_gnt[c]);
      model_eval(c + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_WORDS, 128, depth of shared data memory in 32-bit words; AW = clog2(MEM_WORDS) (7 at default).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-port request (bit 0 = CPU memory stage, bit 1 = debug/loader port); level, held until gnt.
REQ-005 we  input  2  per-port write enable, qualified by req.
REQ-006 addr0, addr1  input  32 each  per-port byte address.
REQ-007 wdata0, wdata1  input  32 each  per-port write data.
REQ-008 gnt  output  2  one-cycle per-port acceptance pulse.
REQ-009 rvalid  output  2  one-cycle per-port read-data-valid pulse.
REQ-010 err  output  2  one-cycle per-port error pulse, coincident with gnt.
REQ-011 rdata  output  32  read data, meaningful only while any rvalid bit is 1.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 mem_en, mem_we  output  1 each  memory access strobe and write strobe.
REQ-014 mem_addr  output  AW  word index into memory.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_rdata  input  32  memory read data, valid the cycle after a mem_en read cycle.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP; one transaction in flight at most.
REQ-018 IDLE: if req != 0, select owner, latch owner's addr, we, wdata and owner index into internal registers, go ACCESS; otherwise stay IDLE.
REQ-019 Arbitration: one requester -> that port; both -> port != last_owner (round-robin); last_owner updates when a transaction enters ACCESS.
REQ-020 Error check at latch time: addr[1:0] != 0 or addr[31:2] >= MEM_WORDS flags the transaction as error.
REQ-021 ACCESS, no error: mem_en=1, mem_we=latched we, mem_addr=latched addr[AW+1:2], mem_wdata=latched wdata, gnt[owner]=1; write -> IDLE, read -> RESP.
REQ-022 ACCESS, error: mem_en=0, mem_we=0, gnt[owner]=1, err[owner]=1, go IDLE; no rvalid for errored reads.
REQ-023 RESP: rvalid[owner]=1, rdata=mem_rdata, go IDLE.
REQ-024 mem_* outputs, gnt, err, rvalid SHALL decode from registered state only (no combinational path from req/addr).
REQ-025 Latency: write req seen in IDLE -> gnt 1 cycle later; read -> gnt 1 cycle later, rvalid 2 cycles later; back-to-back writes every 2 cycles, reads every 3.
REQ-026 Requester may deassert req or change addr/we/wdata after the latch edge; in-flight transaction completes with latched values.
REQ-027 Request dropped before selection in IDLE SHALL be ignored with no pulse.
REQ-028 Only the owner's bit of gnt/rvalid/err may be 1; all three vectors zero outside the states above.
REQ-029 rdata SHALL be 0 when rvalid == 0.

Reset
REQ-030 rst asserted at any time SHALL immediately force IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, gnt=0, rvalid=0, err=0, rdata=0, busy=0, without waiting for clk.
REQ-031 Reset SHALL set last_owner=1, so port 0 wins the first contention.
REQ-032 Transaction interrupted by reset SHALL be dropped: no memory write after reset, no gnt/rvalid.

Verification
REQ-033 Port 0 read addr=0x10, mem_rdata=0x0000_0004 -> gnt=01 at cycle+1 with mem_en=1, mem_we=0, mem_addr=4; rvalid=01, rdata=0x4 at cycle+2.
REQ-034 Both ports write simultaneously (addr0=0x8/wdata0=0xAA, addr1=0xC/wdata1=0xBB) after reset -> port 0 granted first (mem_addr=2), port 1 next (mem_addr=3), gnt pulses 2 cycles apart.
REQ-035 Both ports hold continuous reads -> grants alternate 0,1,0,1; neither port granted twice consecutively.
REQ-036 Port 1 read addr=0x6 (misaligned) and addr=0x200 (out of range, MEM_WORDS=128) -> gnt=10, err=10, mem_en=0, no rvalid.
REQ-037 Port 0 write addr=0x20, rst asserted mid-cycle while in ACCESS -> mem_en/mem_we drop before next edge, busy=0, no gnt; memory word 8 unchanged.
REQ-038 Port 0 pulses req for one cycle with we=0 then drops it -> transaction still completes: gnt=01 then rvalid=01.
